// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: data widths, the reset PC,
// the fetch FSM state encoding and the fetch-address legality check.
package ifu_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_e;

  // A fetch address is usable only if it is word aligned and the whole word fits in memory.
  function automatic logic pc_legal(input logic [31:0] addr, input logic [31:0] last_pc);
    return (addr[1:0] == 2'b00) && (addr <= last_pc);
  endfunction

endpackage

// File: rtl/ifu_hold_buf.sv
// One-entry skid buffer for a fetched {pc, instr} pair that decode did not take.
// Clear wins over capture so a redirect always empties the buffer.
module ifu_hold_buf
  import ifu_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               capture_i,
  input  logic               clear_i,
  input  logic [31:0]        pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               full_o,
  output logic [31:0]        pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic               full_q, full_d;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  always_comb begin
    full_d  = full_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (capture_i) begin
      full_d  = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      full_q  <= full_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign full_o  = full_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Program-counter sequencer for a 1-cycle-latency instruction memory, delivering
// words to decode over valid/ready with redirect, halt and illegal-address handling.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_BYTES = 256
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic [31:0]        imem_addr_o,
  input  logic [INSTR_W-1:0] imem_instr_i,
  output logic               if_valid_o,
  input  logic               if_ready_i,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic [31:0]        if_pc_o,
  input  logic               redirect_valid_i,
  input  logic [31:0]        redirect_pc_i,
  input  logic               halt_i,
  output logic               fault_o
);

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  fetch_state_e       state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        resp_pc_q, resp_pc_d;
  logic               inflight_q, inflight_d;

  logic               hold_full;
  logic [31:0]        hold_pc;
  logic [INSTR_W-1:0] hold_instr;
  logic               hold_capture;
  logic               hold_clear;

  logic               run_en;
  logic               accept;
  logic               issue;
  logic               fetch_legal;
  logic               redirect_legal;

  assign fetch_legal    = pc_legal(fetch_pc_q, LAST_PC);
  assign redirect_legal = pc_legal(redirect_pc_i, LAST_PC);

  ifu_hold_buf u_hold_buf (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .capture_i (hold_capture),
    .clear_i   (hold_clear),
    .pc_i      (resp_pc_q),
    .instr_i   (imem_instr_i),
    .full_o    (hold_full),
    .pc_o      (hold_pc),
    .instr_o   (hold_instr)
  );

  // A redirect kills whatever is being presented in the same cycle.
  always_comb begin
    if_valid_o   = (hold_full | inflight_q) & ~redirect_valid_i;
    if_pc_o      = hold_full ? hold_pc    : resp_pc_q;
    if_instr_o   = hold_full ? hold_instr : imem_instr_i;
    accept       = if_valid_o & if_ready_i;
    hold_capture = inflight_q & ~hold_full & ~accept & ~redirect_valid_i;
    hold_clear   = redirect_valid_i | (hold_full & accept);
  end

  // Issuing waits until the buffer is already empty, which leaves one bubble after a stall.
  always_comb begin
    issue      = run_en & ~halt_i & ~redirect_valid_i & ~hold_full & ~hold_capture & fetch_legal;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = issue;
    if (redirect_valid_i) begin
      fetch_pc_d = redirect_pc_i;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      resp_pc_d  = fetch_pc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A redirect in RUN re-targets the pc, so legality is judged on the new pc next cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (!redirect_valid_i && !fetch_legal) begin
          state_d = S_FAULT;
        end else if (halt_i) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (!halt_i) begin
          state_d = S_RUN;
        end
      end
      S_FAULT: begin
        if (redirect_valid_i && redirect_legal) begin
          state_d = halt_i ? S_HALT : S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    run_en  = (state_q == S_RUN);
    fault_o = (state_q == S_FAULT);
  end

  assign imem_addr_o = fetch_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle-by-cycle stimulus with hand-derived
// expected fetch stream, stall, redirect, fault, halt and reset behaviour.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imemAddr;
  logic [31:0] imemInstr = 32'h0;
  logic        ifValid;
  logic        ifReady = 1'b0;
  logic [31:0] ifInstr;
  logic [31:0] ifPc;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectPc = 32'h0;
  logic        halt = 1'b0;
  logic        fault;

  int checkCount = 0;
  int errorCount = 0;

  instr_fetch_unit #(
    .RESET_PC   (32'h0),
    .IMEM_BYTES (256)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .imem_addr_o      (imemAddr),
    .imem_instr_i     (imemInstr),
    .if_valid_o       (ifValid),
    .if_ready_i       (ifReady),
    .if_instr_o       (ifInstr),
    .if_pc_o          (ifPc),
    .redirect_valid_i (redirectValid),
    .redirect_pc_i    (redirectPc),
    .halt_i           (halt),
    .fault_o          (fault)
  );

  always #5 clk = ~clk;

  // Memory image: every word is a distinct function of its byte address.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return 32'h5A00_0000 ^ {addr[15:0], ~addr[15:0]};
  endfunction

  always @(posedge clk) imemInstr <= memWord(imemAddr);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the next rising edge.
  task automatic applyStimulus(input logic rst, input logic rdy, input logic rv,
                               input logic [31:0] rpc, input logic hlt);
    @(negedge clk);
    reset         = rst;
    ifReady       = rdy;
    redirectValid = rv;
    redirectPc    = rpc;
    halt          = hlt;
    #1;
  endtask

  task automatic expectWord(input string tag, input logic v, input logic [31:0] pc);
    checkOutput({tag, ".valid"}, {31'b0, ifValid}, {31'b0, v});
    if (v) begin
      checkOutput({tag, ".pc"}, ifPc, pc);
      checkOutput({tag, ".instr"}, ifInstr, memWord(pc));
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("rst.valid", {31'b0, ifValid}, 32'h0);
    checkOutput("rst.addr", imemAddr, 32'h0);
    checkOutput("rst.fault", {31'b0, fault}, 32'h0);
  endtask

  initial begin
    $display("[TB] start");

    // Straight-line fetch, one word per cycle from cycle 1
    doReset();
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      expectWord($sformatf("t1.c%0d", c), 1'b1, 32'(4 * (c - 1)));
    end

    // Stall on word 8, then release: 8, bubble, 12, 16
    doReset();
    for (int c = 1; c <= 2; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      expectWord($sformatf("t2.c%0d", c), 1'b1, 32'(4 * (c - 1)));
    end
    for (int c = 3; c <= 5; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      expectWord($sformatf("t2.c%0d", c), 1'b1, 32'h8);
      checkOutput($sformatf("t2.c%0d.addr", c), imemAddr, 32'hC);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    expectWord("t2.c6", 1'b1, 32'h8);
    checkOutput("t2.c6.addr", imemAddr, 32'hC);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    expectWord("t2.c7", 1'b0, 32'h0);
    checkOutput("t2.c7.addr", imemAddr, 32'hC);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    expectWord("t2.c8", 1'b1, 32'hC);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    expectWord("t2.c9", 1'b1, 32'h10);

    // Redirect to 0x40 while 0x10 is presented
    doReset();
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      expectWord($sformatf("t3.c%0d", c), 1'b1, 32'(4 * (c - 1)));
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
    expectWord("t3.c5", 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    expectWord("t3.c6", 1'b0, 32'h0);
    checkOutput("t3.c6.addr", imemAddr, 32'h40);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    expectWord("t3.c7", 1'b1, 32'h40);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    expectWord("t3.c8", 1'b1, 32'h44);

    // Misaligned redirect faults; a legal redirect recovers
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h42, 1'b0);
    expectWord("t4.c9", 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    expectWord("t4.c10", 1'b0, 32'h0);
    checkOutput("t4.c10.fault", {31'b0, fault}, 32'h0);
    for (int c = 11; c <= 12; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      expectWord($sformatf("t4.c%0d", c), 1'b0, 32'h0);
      checkOutput($sformatf("t4.c%0d.fault", c), {31'b0, fault}, 32'h1);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h20, 1'b0);
    expectWord("t4.c13", 1'b0, 32'h0);
    checkOutput("t4.c13.fault", {31'b0, fault}, 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    expectWord("t4.c14", 1'b0, 32'h0);
    checkOutput("t4.c14.fault", {31'b0, fault}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    expectWord("t4.c15", 1'b1, 32'h20);

    // Run off the top of memory: 0xFC is the last word, 0x100 faults
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hF0, 1'b0);
    expectWord("t5.c16", 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    expectWord("t5.c17", 1'b0, 32'h0);
    for (int c = 18; c <= 21; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      expectWord($sformatf("t5.c%0d", c), 1'b1, 32'hF0 + 32'(4 * (c - 18)));
      checkOutput($sformatf("t5.c%0d.fault", c), {31'b0, fault}, 32'h0);
    end
    for (int c = 22; c <= 23; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      expectWord($sformatf("t5.c%0d", c), 1'b0, 32'h0);
      checkOutput($sformatf("t5.c%0d.fault", c), {31'b0, fault}, 32'h1);
      checkOutput($sformatf("t5.c%0d.addr", c), imemAddr, 32'h100);
    end

    // Halt mid-stream, resume, then reset while the hold buffer is full
    doReset();
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      expectWord($sformatf("t6.c%0d", c), 1'b1, 32'(4 * (c - 1)));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    expectWord("t6.c4", 1'b1, 32'hC);
    for (int c = 5; c <= 6; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      expectWord($sformatf("t6.c%0d", c), 1'b0, 32'h0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    expectWord("t6.c7", 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    expectWord("t6.c8", 1'b0, 32'h0);
    checkOutput("t6.c8.addr", imemAddr, 32'h10);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    expectWord("t6.c9", 1'b1, 32'h10);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    expectWord("t6.c10", 1'b1, 32'h14);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    expectWord("t6.c11", 1'b1, 32'h14);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    expectWord("t6.c12", 1'b0, 32'h0);
    checkOutput("t6.c12.addr", imemAddr, 32'h0);
    checkOutput("t6.c12.fault", {31'b0, fault}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    expectWord("t6.c13", 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    expectWord("t6.c14", 1'b1, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
